// File: rtl/vga_rtc_renderer_if.sv
// Bundle between the RTC register file (master) and the VGA renderer (slave):
// digit/edit inputs toward the renderer, sync/colour outputs toward the connector.
interface vga_rtc_renderer_if #(
  parameter int NUM_DIG = 18
);
  localparam int SEL_W = (NUM_DIG / 2 > 1) ? $clog2(NUM_DIG / 2) : 1;

  logic [4*NUM_DIG-1:0] DIGITS;
  logic                 EDIT_EN;
  logic [SEL_W-1:0]     EDIT_SEL;
  logic                 HS;
  logic                 VS;
  logic [11:0]          COLOR_OUT;
  logic                 FRAME_START;

  modport master (output DIGITS, EDIT_EN, EDIT_SEL, input HS, VS, COLOR_OUT, FRAME_START);
  modport slave  (input DIGITS, EDIT_EN, EDIT_SEL, output HS, VS, COLOR_OUT, FRAME_START);
endinterface

// File: rtl/vga_rtc_renderer.sv
// VGA renderer: raster timing, template window and a grid of BCD digit sprites,
// with frame-latched digits, pair blinking and a 2-tick pipe with aligned syncs.
module vga_rtc_renderer #(
  parameter int PIX_DIV = 4,
  parameter int IMG_X0 = 100, IMG_Y0 = 100, IMG_W = 200, IMG_H = 200,
  parameter int DIG_W = 20, DIG_H = 30, ROWS = 3, COLS = 6,
  parameter int COL_X0 = 2, COL_PITCH = 22, GROUP_GAP = 6, ROW_Y0 = 20, ROW_PITCH = 50,
  parameter logic [11:0] TRANSP = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'hFFF,
  parameter int BLINK_FRAMES = 30,
  parameter int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_VIS = 480, V_FP = 10, V_SYNC = 2, V_BP = 33
) (
  input logic CLK,
  input logic RST,
  vga_rtc_renderer_if.slave bus
);
  localparam int NUM_DIG = ROWS * COLS;
  localparam int SEL_W   = (NUM_DIG / 2 > 1) ? $clog2(NUM_DIG / 2) : 1;
  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DIG_SZ  = DIG_W * DIG_H;
  localparam int TA_W    = $clog2(IMG_W * IMG_H);
  localparam int SA_W    = $clog2(10 * DIG_SZ);

  typedef enum logic [1:0] {CLS_BLANK, CLS_BG, CLS_TPL} cls_e;

  // Computed ROM contents (word 0 = 12'h123; digit 7 origin = 12'h0F0 at default size).
  function automatic logic [11:0] tpl_rom(input logic [TA_W-1:0] a);
    return 12'(a) + 12'h123;
  endfunction
  function automatic logic [11:0] spr_rom(input logic [SA_W-1:0] a);
    return (a[1:0] == 2'b11) ? 12'hFFF : (12'(a >> 2) ^ 12'h4EA);
  endfunction

  logic [DIV_W-1:0]     div_q, div_d;
  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic [FC_W-1:0]      fcnt_q, fcnt_d;
  logic                 blink_q, blink_d;
  logic [4*NUM_DIG-1:0] dig_q, dig_d;
  logic                 en_q, en_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  cls_e                 s1_cls_q, s1_cls_d;
  logic [TA_W-1:0]      s1_taddr_q, s1_taddr_d;
  logic [SA_W-1:0]      s1_saddr_q, s1_saddr_d;
  logic                 s1_dig_q, s1_dig_d;
  logic [1:0][1:0]      sync_q, sync_d;
  logic [11:0]          color_q, color_d;

  logic tick, fs, vis, in_tpl, hs_raw, vs_raw, hit_show;
  logic [SA_W-1:0] hit_addr;
  logic [11:0] tpl_px, spr_px;
  int hx, vy;
  logic [NUM_DIG-1:0] slot_hit, slot_show;
  logic [NUM_DIG-1:0][SA_W-1:0] slot_addr;

  assign tick   = (div_q == DIV_W'(PIX_DIV - 1));
  assign fs     = tick && (h_q == '0) && (v_q == '0);
  assign hx     = int'(h_q) - IMG_X0;
  assign vy     = int'(v_q) - IMG_Y0;
  assign vis    = (int'(h_q) < H_VIS) && (int'(v_q) < V_VIS);
  assign in_tpl = (hx >= 0) && (hx < IMG_W) && (vy >= 0) && (vy < IMG_H);
  assign hs_raw = !((int'(h_q) >= H_VIS + H_FP) && (int'(h_q) < H_VIS + H_FP + H_SYNC));
  assign vs_raw = !((int'(v_q) >= V_VIS + V_FP) && (int'(v_q) < V_VIS + V_FP + V_SYNC));

  // One hit detector per slot; slot rectangles never overlap.
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_slot
    localparam int C  = k % COLS;
    localparam int R  = k / COLS;
    localparam int SX = COL_X0 + C * COL_PITCH + (C / 2) * GROUP_GAP;
    localparam int SY = ROW_Y0 + R * ROW_PITCH;
    logic [3:0] d;
    assign d            = dig_q[4*k +: 4];
    assign slot_hit[k]  = in_tpl && (hx >= SX) && (hx < SX + DIG_W) && (vy >= SY) && (vy < SY + DIG_H);
    assign slot_show[k] = (d <= 4'd9) && !(en_q && blink_q && (int'(sel_q) == k / 2));
    assign slot_addr[k] = SA_W'(int'(d) * DIG_SZ + (vy - SY) * DIG_W + (hx - SX));
  end

  assign tpl_px = tpl_rom(s1_taddr_q);
  assign spr_px = spr_rom(s1_saddr_q);

  always_comb begin
    hit_addr = '0;
    hit_show = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (slot_hit[k]) begin
        hit_addr = slot_addr[k];
        hit_show = slot_show[k];
      end
    end
  end

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    h_d        = h_q;
    v_d        = v_q;
    fcnt_d     = fcnt_q;
    blink_d    = blink_q;
    dig_d      = dig_q;
    en_d       = en_q;
    sel_d      = sel_q;
    s1_cls_d   = s1_cls_q;
    s1_taddr_d = s1_taddr_q;
    s1_saddr_d = s1_saddr_q;
    s1_dig_d   = s1_dig_q;
    sync_d     = sync_q;
    color_d    = color_q;
    if (tick) begin
      h_d = (h_q == HW'(H_TOT - 1)) ? '0 : h_q + 1'b1;
      if (h_q == HW'(H_TOT - 1)) v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
      s1_cls_d   = !vis ? CLS_BLANK : (in_tpl ? CLS_TPL : CLS_BG);
      s1_taddr_d = TA_W'(vy * IMG_W + hx);
      s1_saddr_d = hit_addr;
      s1_dig_d   = hit_show;
      sync_d     = {sync_q[0], hs_raw, vs_raw};
      case (s1_cls_q)
        CLS_BLANK: color_d = 12'h000;
        CLS_BG:    color_d = BG_COLOR;
        default:   color_d = (s1_dig_q && spr_px != TRANSP) ? spr_px : tpl_px;
      endcase
    end
    // Shadows and blink state only move at frame start, so a frame never tears.
    if (fs) begin
      dig_d = bus.DIGITS;
      en_d  = bus.EDIT_EN;
      sel_d = bus.EDIT_SEL;
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blink_d = !blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      fcnt_q     <= '0;
      blink_q    <= 1'b0;
      dig_q      <= '0;
      en_q       <= 1'b0;
      sel_q      <= '0;
      s1_cls_q   <= CLS_BLANK;
      s1_taddr_q <= '0;
      s1_saddr_q <= '0;
      s1_dig_q   <= 1'b0;
      sync_q     <= '1;
      color_q    <= 12'h000;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      fcnt_q     <= fcnt_d;
      blink_q    <= blink_d;
      dig_q      <= dig_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      s1_cls_q   <= s1_cls_d;
      s1_taddr_q <= s1_taddr_d;
      s1_saddr_q <= s1_saddr_d;
      s1_dig_q   <= s1_dig_d;
      sync_q     <= sync_d;
      color_q    <= color_d;
    end
  end

  assign bus.HS          = sync_q[1][1];
  assign bus.VS          = sync_q[1][0];
  assign bus.COLOR_OUT   = color_q;
  assign bus.FRAME_START = fs && !RST;
endmodule

// File: tb/tb_vga_rtc_renderer.sv
// Bench for vga_rtc_renderer on a shrunken raster: per-cycle reference model,
// a raster-ordered pixel table and hand sequences for blink, tearing and reset.
module tb_vga_rtc_renderer;
  localparam int PD = 2, X0 = 2, Y0 = 3, IW = 36, IH = 24, DW = 3, DH = 4;
  localparam int NR = 2, NC = 6, CX0 = 1, CP = 5, GG = 2, RY0 = 2, RP = 10, BF = 2;
  localparam int HV = 44, HF = 4, HSW = 8, HB = 4, VV = 30, VF = 3, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB, VT = VV + VF + VSW + VB, FR = HT * VT, ND = NR * NC;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  vga_rtc_renderer_if #(.NUM_DIG(ND)) bus();

  vga_rtc_renderer #(
    .PIX_DIV(PD), .IMG_X0(X0), .IMG_Y0(Y0), .IMG_W(IW), .IMG_H(IH), .DIG_W(DW), .DIG_H(DH),
    .ROWS(NR), .COLS(NC), .COL_X0(CX0), .COL_PITCH(CP), .GROUP_GAP(GG), .ROW_Y0(RY0),
    .ROW_PITCH(RP), .TRANSP(12'hFFF), .BG_COLOR(12'hFFF), .BLINK_FRAMES(BF),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct { int h; int v; logic [11:0] exp; } vec_t;
  vec_t tbl [13];

  int tests = 0, fails = 0, k = 0;
  logic [4*ND-1:0] cap_dig [0:63];
  logic            cap_en  [0:63];
  logic [2:0]      cap_sel [0:63];

  function automatic logic [11:0] m_tpl(int a);
    return 12'((a + 'h123) % 4096);
  endfunction
  function automatic logic [11:0] m_spr(int a);
    if (a % 4 == 3) return 12'hFFF;
    return 12'((a / 4) ^ 'h4EA);
  endfunction

  // Frame f sees inputs latched at its own start; blink phase after f+1 frame starts.
  function automatic logic [11:0] m_pixel(int h, int v, int f);
    int tx, ty, sx, sy, s, d;
    logic hid;
    logic [11:0] px;
    if (h >= HV || v >= VV) return 12'h000;
    tx = h - X0; ty = v - Y0;
    if (tx < 0 || tx >= IW || ty < 0 || ty >= IH) return 12'hFFF;
    hid = cap_en[f] && ((((f + 1) / BF) % 2) == 1);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        sx = CX0 + c * CP + (c / 2) * GG; sy = RY0 + r * RP;
        if (tx >= sx && tx < sx + DW && ty >= sy && ty < sy + DH) begin
          s = r * NC + c;
          d = int'(cap_dig[f][4*s +: 4]);
          if (d <= 9 && !(hid && int'(cap_sel[f]) == s / 2)) begin
            px = m_spr(d * DW * DH + (ty - sy) * DW + (tx - sx));
            if (px != 12'hFFF) return px;
          end
        end
      end
    return m_tpl(ty * IW + tx);
  endfunction

  task automatic check();
    int t, p, h, v;
    logic [11:0] ec;
    logic ehs, evs, efs;
    t = k / PD; h = -1; v = -1;
    efs = (k % PD == PD - 1) && (t % FR == 0);
    if (t < 2) begin
      ec = 12'h000; ehs = 1'b1; evs = 1'b1;
    end else begin
      p = t - 2; h = p % HT; v = (p / HT) % VT;
      ec  = m_pixel(h, v, p / FR);
      ehs = !(h >= HV + HF && h < HV + HF + HSW);
      evs = !(v >= VV + VF && v < VV + VF + VSW);
    end
    tests++;
    if ({bus.COLOR_OUT, bus.HS, bus.VS, bus.FRAME_START} !== {ec, ehs, evs, efs}) begin
      fails++;
      $display("FAIL model k=%0d pix(%0d,%0d) got col=%h hs=%b vs=%b fs=%b exp col=%h hs=%b vs=%b fs=%b",
               k, h, v, bus.COLOR_OUT, bus.HS, bus.VS, bus.FRAME_START, ec, ehs, evs, efs);
    end
  endtask

  task automatic step();
    int t;
    t = k / PD;
    if (k % PD == PD - 1 && t % FR == 0 && t / FR < 64) begin
      cap_dig[t/FR] = bus.DIGITS; cap_en[t/FR] = bus.EDIT_EN; cap_sel[t/FR] = bus.EDIT_SEL;
    end
    k++;
    @(negedge clk);
    check();
  endtask

  task automatic release_reset();
    rst = 1'b0; k = 0;
    check();
  endtask

  // Advance to the first cycle on which pixel (h,v) of frame f is on COLOR_OUT.
  task automatic wait_pix(int h, int v, int f);
    int tk;
    tk = (f * FR + v * HT + h + 2) * PD;
    while (k < tk) step();
    if (k != tk) begin
      tests++; fails++;
      $display("FAIL wait_pix (%0d,%0d,f%0d) at k=%0d required k=%0d", h, v, f, k, tk);
    end
  endtask

  task automatic cmp_col(string name, logic [11:0] exp);
    tests++;
    if (bus.COLOR_OUT !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, bus.COLOR_OUT, exp);
    end
  endtask

  initial begin
    logic [4*ND-1:0] dv;
    int tk, fs_k;
    tbl[0]  = '{0, 0, 12'hFFF};   tbl[1]  = '{2, 3, 12'h123};   tbl[2]  = '{3, 5, 12'h4FF};
    tbl[3]  = '{6, 5, 12'h16F};   tbl[4]  = '{8, 5, 12'h171};   tbl[5]  = '{15, 5, 12'h4E3};
    tbl[6]  = '{50, 5, 12'h000};  tbl[7]  = '{3, 6, 12'h190};   tbl[8]  = '{4, 6, 12'h4FC};
    tbl[9]  = '{38, 10, 12'hFFF}; tbl[10] = '{3, 15, 12'h4F1};  tbl[11] = '{10, 27, 12'hFFF};
    tbl[12] = '{5, 32, 12'h000};

    dv = '0; dv[3:0] = 4'd7; dv[7:4] = 4'hC; dv[11:8] = 4'd3; dv[27:24] = 4'd9;
    bus.DIGITS = dv; bus.EDIT_EN = 1'b0; bus.EDIT_SEL = 3'd0;
    repeat (3) @(negedge clk);
    release_reset();

    for (int i = 0; i < 13; i++) begin
      wait_pix(tbl[i].h, tbl[i].v, 0);
      cmp_col($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Blink pair 0 every BF frames; pair 1 stays visible.
    bus.EDIT_EN = 1'b1; bus.EDIT_SEL = 3'd0;
    wait_pix(3, 5, 1);  cmp_col("blink_f1_slot0", 12'h16C);
    wait_pix(15, 5, 1); cmp_col("blink_f1_slot2", 12'h4E3);
    wait_pix(3, 5, 2);  cmp_col("blink_f2_slot0", 12'h16C);
    wait_pix(3, 5, 3);  cmp_col("blink_f3_slot0", 12'h4FF);
    wait_pix(3, 5, 4);  cmp_col("blink_f4_slot0", 12'h4FF);
    bus.EDIT_SEL = 3'd7;
    wait_pix(3, 5, 5);  cmp_col("sel_out_of_range", 12'h4FF);

    // Digit change mid-frame must wait for the next frame.
    wait_pix(0, 10, 6);
    bus.DIGITS[27:24] = 4'd2;
    wait_pix(3, 15, 6); cmp_col("no_tear_old", 12'h4F1);
    wait_pix(3, 15, 7); cmp_col("no_tear_new", 12'h4EC);

    // Random input churn checked by the model.
    while (k < 10 * FR * PD) begin
      if (k % 200 == 0) begin
        bus.DIGITS = {$urandom, $urandom};
        bus.EDIT_EN = 1'($urandom);
        bus.EDIT_SEL = 3'($urandom_range(0, 7));
      end
      step();
    end

    // Mid-frame reset while the counters hold (30,20).
    tk = (10 * FR + 20 * HT + 30) * PD;
    while (k < tk) step();
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.COLOR_OUT, bus.HS, bus.VS, bus.FRAME_START} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid got col=%h hs=%b vs=%b fs=%b exp col=000 hs=1 vs=1 fs=0",
               bus.COLOR_OUT, bus.HS, bus.VS, bus.FRAME_START);
    end
    @(negedge clk);
    release_reset();
    fs_k = -1;
    for (int i = 0; i < 4 * PD; i++) begin
      if (bus.FRAME_START === 1'b1) begin fs_k = k; break; end
      step();
    end
    tests++;
    if (fs_k != PD - 1) begin
      fails++;
      $display("FAIL first_frame_start got cycle %0d exp %0d", fs_k, PD - 1);
    end
    while (k < (FR + 4) * PD) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at k=%0d", k);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_rtc_renderer.md
Name: vga_rtc_renderer

Overview:
- Self-contained VGA renderer for the RTC display: 640x480 timing generator, template ROM window and a parametrised grid of BCD digit sprites overlaid on the template.
- Adds frame-latched digit inputs, blinking of an edited digit pair, sprite transparency and a pipelined read path with aligned sync outputs.
- Sits between the RTC controller/register file and the VGA connector.

Parameters:
- PIX_DIV, 4, CLK cycles per pixel tick (100 MHz -> 25 MHz)
- IMG_X0, 100, template left edge on screen
- IMG_Y0, 100, template top edge on screen
- IMG_W, 200, template width; IMG_H, 200, template height (ROM depth IMG_W*IMG_H)
- DIG_W, 20, digit sprite width; DIG_H, 30, digit sprite height (ROM depth 10*DIG_W*DIG_H)
- ROWS, 3, digit rows; COLS, 6, digits per row (NUM_DIG = ROWS*COLS)
- COL_X0, 2, first digit x within template; COL_PITCH, 22, digit x pitch; GROUP_GAP, 6, extra x gap after each digit pair
- ROW_Y0, 20, first row y within template; ROW_PITCH, 50, row y pitch
- TRANSP, 12'hFFF, sprite colour treated as transparent
- BG_COLOR, 12'hFFF, colour of visible area outside the template
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- DIGITS  in  4*NUM_DIG  BCD digits; slot k is DIGITS[4k+3:4k]; slot order row-major, row 0 col 0 first
- EDIT_EN  in  1  enables blinking of the selected pair
- EDIT_SEL  in  clog2(NUM_DIG/2)  selected pair index p (slots 2p, 2p+1)
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- COLOR_OUT  out  12  RGB444 pixel
- FRAME_START  out  1  one-CLK pulse on the pixel tick where h=0, v=0

Behaviour:
- Reset (synchronous, CLK edge with RST=1): divider, h, v, pipeline, frame counter = 0; HS=VS=1; COLOR_OUT=0; FRAME_START=0; blink phase = shown; digit shadow = 0.
- Pixel tick: asserted when divider = PIX_DIV-1; divider wraps to 0. All pipeline stages advance only on a tick.
- Horizontal: 800 pixels. Visible 0-639, front porch 640-655, sync 656-751 (HS low), back porch 752-799.
- Vertical: 525 lines, advancing when h wraps 799->0. Visible 0-479, sync lines 490-491 (VS low), wrap 524->0.
- Frame start, on the tick with h=0, v=0:
  - DIGITS, EDIT_EN and EDIT_SEL are copied into shadow registers; rendering uses only the shadows, so there is no tearing.
  - Frame counter increments; when it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Stage 1 (registered):
  - Classify the pixel as blank, background, template or digit.
  - Template address = (v-IMG_Y0)*IMG_W + (h-IMG_X0).
  - Digit slot (r,c) occupies template-relative x from COL_X0 + c*COL_PITCH + (c/2)*GROUP_GAP, width DIG_W, and y from ROW_Y0 + r*ROW_PITCH, height DIG_H.
  - Digit ROM address = d*DIG_W*DIG_H + dy*DIG_W + dx. All address arithmetic is unsigned and sized to its ROM depth.
- Stage 2 (registered): ROM reads and colour mux, in priority order:
  1. blank (h>=640 or v>=480) -> 12'h000
  2. outside template -> BG_COLOR
  3. inside a digit slot with shadow digit <=9, not hidden, and sprite pixel != TRANSP -> sprite pixel
  4. otherwise -> template pixel
- Hidden: EDIT_EN shadow = 1, the slot is in pair EDIT_SEL shadow, and blink phase = hidden.
- Digit values 10-15 render as blank, showing the template.
- EDIT_SEL >= NUM_DIG/2 hides nothing.
- Latency: COLOR_OUT for pixel (h,v) appears 2 pixel ticks after the counters hold (h,v). HS/VS are delayed through the same 2-stage pipe, so they stay aligned with colour.
- Outputs change only on pixel ticks, except FRAME_START (1 CLK wide) and reset.
- Reset mid-frame: next cycle follows the reset values; the frame restarts at h=0, v=0, and FRAME_START pulses on the first tick after RST falls.

Test Plan:
- Reset with PIX_DIV=4, run 1 frame -> FRAME_START period 4*800*525 = 1,680,000 CLK; HS low for 96*4 CLK per line; VS low for 2 lines; COLOR_OUT = 0 throughout h>=640.
- Pixel (50,50) and pixel (100,100) with template word 0 = 12'h123 -> COLOR_OUT = BG_COLOR (12'hFFF) and 12'h123 respectively, each 2 ticks after the counter value.
- DIGITS slot 0 = 7, sprite ROM for digit 7 at dx=0, dy=0 = 12'h0F0 -> pixel (102,120) shows 12'h0F0; a sprite pixel equal to 12'hFFF shows the template instead.
- Change DIGITS mid-frame at v=200 -> display holds old digits until the next FRAME_START, then shows the new value for the entire frame.
- EDIT_EN=1, EDIT_SEL=1, BLINK_FRAMES=2 -> slots 2 and 3 alternate shown/hidden every 2 frames; other slots are unaffected; EDIT_SEL=9 hides nothing.
- Slot digit = 4'hC -> template shown in that slot; assert RST at h=300, v=300 -> outputs take reset values next CLK and the frame restarts at (0,0).
